binary_add_pipe: RTL and testbench
==================================

Name: binary_add_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; next generation of the team's fixed-width registered ripple adder.
- Splits a WIDTH-bit carry chain into STAGES registered segments. Accepts one operation per cycle and returns sum, carry-out and signed overflow after STAGES enabled cycles.
- Sits between operand registers and accumulator/datapath logic wherever WIDTH is too wide for one-cycle ripple timing.

Parameters:
- WIDTH, 12: operand and result width in bits; legal range 2 and up.
- STAGES, 3: number of pipeline segments; legal range 1 to WIDTH.
- SEG, derived: ceil(WIDTH/STAGES). Segment k covers bits [k*SEG, min((k+1)*SEG, WIDTH)-1]; the last segment may be narrower.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, 1: pipeline advance. Low = every internal and output register holds.
- in_valid, input, 1: operands valid this cycle; sampled only when en=1.
- sub, input, 1: 0 = A+B, 1 = A-B.
- A, input, WIDTH: operand A.
- B, input, WIDTH: operand B.
- S, output, WIDTH: registered result.
- cout, output, 1: carry out of the MSB. For sub this is raw carry, so 1 = no borrow.
- ovf, output, 1: signed overflow.
- out_valid, output, 1: S/cout/ovf hold a new result this cycle.

Behaviour:
- Reset (async assert, sync release to clk): S=0, cout=0, ovf=0, out_valid=0. All stage valid bits, carries and data registers clear.
- Subtraction: B is replaced by ~B and the stage-0 carry-in is 1. Addition uses B and carry-in 0.
- Stage k (0..STAGES-1):
  - Adds segment k of A and B' plus carry from the stage k-1 register (stage 0 uses the sub-derived carry-in).
  - Registers the segment sum, carry-out and valid.
  - Already-computed lower result bits and not-yet-used upper operand bits are delayed alongside, so each operation stays aligned.
- Final-stage register drives S, cout and out_valid directly.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, computed in the final segment.
- Latency: result of an operation accepted in enabled cycle n appears with out_valid=1 after enabled cycle n+STAGES-1 (STAGES enabled clock edges). Stall cycles (en=0) add nothing else.
- Throughput: one operation per enabled cycle; back-to-back in_valid is fully supported.
- Bubbles: in_valid=0 with en=1 inserts a bubble. When a bubble reaches the output, out_valid=0 and S/cout/ovf hold the last valid result.
- en=0: all registers hold, including out_valid. No input is sampled and in_valid is ignored.
- STAGES=1: reduces to a one-cycle registered adder, with the same behaviour as the current 12-bit block when WIDTH=12 and sub=0.
- Wrap-around: the result is modulo 2^WIDTH; carry/borrow is reported only on cout.
- Reset mid-operation: all in-flight operations are discarded and no out_valid is produced for them.

Optional Feature:
- Macro: BINARY_ADD_SAT_EN.
- When defined, signed saturation on ovf=1:
  - Positive overflow (result MSB=1, both effective operands positive): S = 0 followed by all ones (for example 0x7FF).
  - Negative overflow: S = 1 followed by all zeros (for example 0x800).
  - ovf still asserts; cout is unchanged.
- Saturation is applied in the final stage with no added latency.
- When undefined: S is the wrapped result and no saturation logic is built.

Test Plan (WIDTH=12, STAGES=3 unless noted):
- Carry across all segments: A=0xFFF, B=0x001, sub=0, en=1 -> 3 edges later S=0x000, cout=1, ovf=0, out_valid=1 for one cycle.
- Signed overflow: A=0x7FF, B=0x001 -> S=0x800, ovf=1, cout=0. With BINARY_ADD_SAT_EN: S=0x7FF, ovf=1.
- Subtract with borrow: A=0x005, B=0x007, sub=1 -> S=0xFFE, cout=0, ovf=0. Then A=0x007, B=0x005 -> S=0x002, cout=1.
- Back-to-back plus bubble: issue 0x100+0x023, 0x0FF+0x001, bubble, 0x800-0x001 on consecutive cycles -> outputs 0x123, 0x100, then out_valid=0 with S held at 0x100, then 0x7FF with ovf=1. No reordering.
- Stall: en=0 for 4 cycles with 2 operations in flight -> all outputs frozen. After en returns to 1, results emerge in order, each STAGES enabled edges after issue.
- Reset mid-flight: assert rst_n=0 asynchronously between edges with 3 operations in flight -> S=0, out_valid=0 immediately. After release, no stale out_valid appears. Repeat the first scenario with STAGES=1 and WIDTH=12 -> 1-cycle latency.

Source files
------------

// File: rtl/binary_add_pipe.sv
// rtl/binary_add_pipe.sv - pipelined two's-complement adder/subtractor with segmented carry chain
//
// Splits a WIDTH-bit ripple carry chain into STAGES registered segments of
// SEG = ceil(WIDTH/STAGES) bits. One operation is accepted per enabled cycle
// and its result appears STAGES enabled edges later.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   en        - pipeline advance; low freezes every register
//   in_valid  - operands valid (sampled only when en=1)
//   sub       - 0: A+B, 1: A-B
//   A, B      - WIDTH-bit operands
//   S         - registered WIDTH-bit result (holds across bubbles)
//   cout      - raw carry out of the MSB (for sub, 1 = no borrow)
//   ovf       - signed overflow
//   out_valid - S/cout/ovf carry a new result this cycle
//
// Optional feature macro: BINARY_ADD_SAT_EN (signed saturation of S on ovf).

module binary_add_pipe #(
  parameter int WIDTH  = 12,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  localparam int SEG  = (WIDTH + STAGES - 1) / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage registers. a/b carry the full operands (b already inverted for
  // sub) so the upper segments still to be added travel with the operation;
  // s carries the low result bits produced so far.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];
  logic             v_q [STAGES];
  logic             v_d [STAGES];
  logic             ovf_q;
  logic             ovf_d;

  // Inputs seen by each stage: ports for stage 0, previous register otherwise.
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];

  assign a_in[0] = A;
  assign b_in[0] = sub ? ~B : B;
  assign s_in[0] = '0;
  assign c_in[0] = sub;
  assign v_in[0] = in_valid;

  genvar g;
  generate
    for (g = 1; g < STAGES; g++) begin : g_link
      assign a_in[g] = a_q[g-1];
      assign b_in[g] = b_q[g-1];
      assign s_in[g] = s_q[g-1];
      assign c_in[g] = c_q[g-1];
      assign v_in[g] = v_q[g-1];
    end
  endgenerate

  logic [WIDTH-1:0] seg_sum;
  logic             seg_c;
  logic             ovf_now;

  always_comb begin
    seg_sum = '0;
    seg_c   = 1'b0;
    ovf_now = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      seg_sum = s_in[k];
      seg_c   = c_in[k];
      // Ripple only over this stage's bit range; an empty trailing segment
      // (possible when SEG rounds up) simply forwards the carry.
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= k * SEG && i < (k + 1) * SEG) begin
          seg_sum[i] = a_in[k][i] ^ b_in[k][i] ^ seg_c;
          seg_c      = (a_in[k][i] & b_in[k][i]) | (seg_c & (a_in[k][i] ^ b_in[k][i]));
        end
      end
      v_d[k] = v_in[k];
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      c_d[k] = c_q[k];
      // Data registers only load real operations, so the final stage keeps
      // the last valid result visible while bubbles pass through.
      if (v_in[k]) begin
        a_d[k] = a_in[k];
        b_d[k] = b_in[k];
        s_d[k] = seg_sum;
        c_d[k] = seg_c;
      end
    end

    // seg_sum now holds the final stage's full result. Same-sign effective
    // operands with a differently-signed sum is exactly carry-in XOR
    // carry-out at the MSB.
    ovf_now = (a_in[LAST][WIDTH-1] == b_in[LAST][WIDTH-1]) &&
              (seg_sum[WIDTH-1] != a_in[LAST][WIDTH-1]);
    ovf_d   = ovf_q;
    if (v_in[LAST]) begin
      ovf_d = ovf_now;
`ifdef BINARY_ADD_SAT_EN
      if (ovf_now) begin
        s_d[LAST] = a_in[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign S         = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;
  assign out_valid = v_q[LAST];

endmodule

// File: tb/tb_binary_add_pipe.sv
// tb/tb_binary_add_pipe.sv - self-checking bench for binary_add_pipe (STAGES=3 and STAGES=1)

module tb_binary_add_pipe;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         in_valid;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] s3, s1;
  logic         c3, c1, o3, o1, v3, v1;

  always #5 clk = ~clk;

  binary_add_pipe #(.WIDTH(W), .STAGES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .sub(sub),
    .A(A), .B(B), .S(s3), .cout(c3), .ovf(o3), .out_valid(v3)
  );

  binary_add_pipe #(.WIDTH(W), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .sub(sub),
    .A(A), .B(B), .S(s1), .cout(c1), .ovf(o1), .out_valid(v1)
  );

  typedef struct {
    logic         v;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_s;
    logic         exp_c;
    logic         exp_o;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  res_t q3[$];
  res_t q1[$];
  res_t e3, e1;

  // Arithmetic reference: true signed/unsigned results, then wrapped.
  function automatic res_t ref_op(logic [W-1:0] a, logic [W-1:0] b, logic s);
    res_t        r;
    int          sa, sb, t;
    int unsigned ua, ub;
    ua  = a;
    ub  = b;
    sa  = $signed(a);
    sb  = $signed(b);
    t   = s ? sa - sb : sa + sb;
    r.v = 1'b1;
    r.c = s ? (ua >= ub) : ((ua + ub) > 4095);
    r.o = (t > 2047) || (t < -2048);
    r.s = t[W-1:0];
`ifdef BINARY_ADD_SAT_EN
    if (r.o) r.s = (t > 0) ? 12'h7FF : 12'h800;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q3.delete();
    q1.delete();
    e3 = '{1'b0, '0, 1'b0, 1'b0};
    e1 = '{1'b0, '0, 1'b0, 1'b0};
  endtask

  // Each enabled edge shifts one slot (operation or bubble) into a queue of
  // depth STAGES; the oldest slot is what the output shows.
  task automatic model_edge(input logic e, input logic v, input logic s,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    if (e) begin
      r   = ref_op(a, b, s);
      r.v = v;
      q3.push_back(r);
      if (q3.size() > 3) void'(q3.pop_front());
      if (q3.size() == 3 && q3[0].v) e3 = q3[0];
      else e3.v = 1'b0;
      q1.push_back(r);
      if (q1.size() > 1) void'(q1.pop_front());
      if (q1[0].v) e1 = q1[0];
      else e1.v = 1'b0;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".S3"},    s3, e3.s);
    chk({tag, ".cout3"}, c3, e3.c);
    chk({tag, ".ovf3"},  o3, e3.o);
    chk({tag, ".vld3"},  v3, e3.v);
    chk({tag, ".S1"},    s1, e1.s);
    chk({tag, ".cout1"}, c1, e1.c);
    chk({tag, ".ovf1"},  o1, e1.o);
    chk({tag, ".vld1"},  v1, e1.v);
  endtask

  task automatic step(input logic e, input logic v, input logic s,
                      input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    en       = e;
    in_valid = v;
    sub      = s;
    A        = a;
    B        = b;
    @(posedge clk);
    model_edge(e, v, s, a, b);
    #1;
    check_outs(tag);
  endtask

  vec_t tbl[7];

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; sub = 1'b0; A = '0; B = '0;
    model_reset();

    tbl[0] = '{12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0};
    tbl[1] = '{12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1};
    tbl[2] = '{12'h005, 12'h007, 1'b1, 12'hFFE, 1'b0, 1'b0};
    tbl[3] = '{12'h007, 12'h005, 1'b1, 12'h002, 1'b1, 1'b0};
    tbl[4] = '{12'h100, 12'h023, 1'b0, 12'h123, 1'b0, 1'b0};
    tbl[5] = '{12'h0FF, 12'h001, 1'b0, 12'h100, 1'b0, 1'b0};
    tbl[6] = '{12'h800, 12'h001, 1'b1, 12'h7FF, 1'b1, 1'b1};
`ifdef BINARY_ADD_SAT_EN
    tbl[1].exp_s = 12'h7FF;
    tbl[6].exp_s = 12'h800;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: STAGES=1 result after one edge, STAGES=3 after three.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, tbl[i].sub, tbl[i].a, tbl[i].b, "tbl_issue");
      chk("tbl.S1",    s1, tbl[i].exp_s);
      chk("tbl.cout1", c1, tbl[i].exp_c);
      chk("tbl.ovf1",  o1, tbl[i].exp_o);
      chk("tbl.vld1",  v1, 1);
      step(1'b1, 1'b0, 1'b0, 12'h000, 12'h000, "tbl_b1");
      chk("tbl.early_vld3", v3, 0);
      step(1'b1, 1'b0, 1'b0, 12'h000, 12'h000, "tbl_b2");
      chk("tbl.S3",    s3, tbl[i].exp_s);
      chk("tbl.cout3", c3, tbl[i].exp_c);
      chk("tbl.ovf3",  o3, tbl[i].exp_o);
      chk("tbl.vld3",  v3, 1);
      step(1'b1, 1'b0, 1'b0, 12'h000, 12'h000, "tbl_b3");
      chk("tbl.one_cycle_vld3", v3, 0);
      chk("tbl.hold_S3",        s3, tbl[i].exp_s);
    end

    // Back-to-back with a bubble
    step(1'b1, 1'b1, 1'b0, 12'h100, 12'h023, "b2b");
    step(1'b1, 1'b1, 1'b0, 12'h0FF, 12'h001, "b2b");
    step(1'b1, 1'b0, 1'b0, 12'h000, 12'h000, "b2b");
    chk("b2b.first_S3", s3, 12'h123);
    step(1'b1, 1'b1, 1'b1, 12'h800, 12'h001, "b2b");
    chk("b2b.second_S3", s3, 12'h100);
    step(1'b1, 1'b0, 1'b0, 12'h000, 12'h000, "b2b");
    chk("b2b.bubble_vld3", v3, 0);
    chk("b2b.bubble_S3",   s3, 12'h100);
    step(1'b1, 1'b0, 1'b0, 12'h000, 12'h000, "b2b");
    chk("b2b.last_S3",   s3, tbl[6].exp_s);
    chk("b2b.last_ovf3", o3, 1);

    // Stall with two operations in flight; in_valid during the stall is ignored.
    step(1'b1, 1'b1, 1'b0, 12'h3A5, 12'h15A, "stall");
    step(1'b1, 1'b1, 1'b1, 12'h010, 12'h020, "stall");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 12'hABC, 12'h123, "stall_hold");
      chk("stall.frozen_vld3", v3, 0);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 12'h000, 12'h000, "stall_drain");

    // Asynchronous reset with three operations in flight
    step(1'b1, 1'b1, 1'b0, 12'h111, 12'h222, "rst_mid");
    step(1'b1, 1'b1, 1'b0, 12'h333, 12'h444, "rst_mid");
    step(1'b1, 1'b1, 1'b1, 12'h555, 12'h666, "rst_mid");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.S3",   s3, 0);
    chk("rst_mid.vld3", v3, 0);
    chk("rst_mid.S1",   s1, 0);
    chk("rst_mid.vld1", v1, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 12'h000, 12'h000, "rst_after");

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           12'($urandom), 12'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
